// File: rtl/control_unit.sv
// Multi-cycle control FSM for a small RV32 add/sub/addi datapath.
// Sequences fetch, decode, operand load, execute and PC update, and halts on
// any unsupported encoding until reset.
module control_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        ALU_carry,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        ir_en,
   output logic        a_en,
   output logic        b_en,
   output logic        pc_en,
   output logic        immgen_bus_en,
   output logic        ALU_bus_en,
   output logic        pc_bus_en,
   output logic        rf_bus_en,
   output logic        rd_bus_en,
   output logic        rf_wen,
   output logic        rf_ren,
   output logic [4:0]  rf_addr_sel,
   output logic        sel_alu_func,
   output logic        pc_inc,
   output logic        carry_flag,
   output logic        halted,
   output logic [31:0] instret
);

   typedef enum logic [3:0] {
      FETCH_REQ, FETCH_LD, DECODE, RS1, RS2, IMM, EXEC, UPDATE_PC, HALT
   } state_t;

   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ADDI, OP_ILL} op_t;

   state_t     state, next;
   op_t        dec_op, op_q;
   logic [4:0] rd_q, rs1_q, rs2_q;

   // Classify the instruction word currently presented by the IR
   always_comb begin
      dec_op = OP_ILL;
      if (instr[6:0] == 7'b0110011 && instr[14:12] == 3'b000) begin
         if (instr[31:25] == 7'b0000000)      dec_op = OP_ADD;
         else if (instr[31:25] == 7'b0100000) dec_op = OP_SUB;
      end else if (instr[6:0] == 7'b0010011 && instr[14:12] == 3'b000) begin
         dec_op = OP_ADDI;
      end
   end

   // State register, latched instruction fields, carry and retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH_REQ;
         op_q       <= OP_ADD;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         carry_flag <= 1'b0;
         instret    <= '0;
      end else begin
         state <= next;
         if (state == DECODE) begin
            op_q  <= dec_op;
            rd_q  <= instr[11:7];
            rs1_q <= instr[19:15];
            rs2_q <= instr[24:20];
         end
         if (state == EXEC)      carry_flag <= ALU_carry;
         if (state == UPDATE_PC) instret    <= instret + 32'd1;
      end
   end

   // Next-state and Moore output decode; reset masks every control output
   always_comb begin
      next          = state;
      mem_req       = 1'b0;
      ir_en         = 1'b0;
      a_en          = 1'b0;
      b_en          = 1'b0;
      pc_en         = 1'b0;
      immgen_bus_en = 1'b0;
      ALU_bus_en    = 1'b0;
      pc_bus_en     = 1'b0;
      rf_bus_en     = 1'b0;
      rd_bus_en     = 1'b0;
      rf_wen        = 1'b0;
      rf_ren        = 1'b0;
      rf_addr_sel   = '0;
      sel_alu_func  = 1'b0;
      pc_inc        = 1'b0;
      halted        = 1'b0;
      case (state)
         FETCH_REQ: begin
            pc_bus_en = 1'b1;
            mem_req   = 1'b1;
            if (mem_ack) next = FETCH_LD;
         end
         FETCH_LD: begin
            rd_bus_en = 1'b1;
            ir_en     = 1'b1;
            next      = DECODE;
         end
         DECODE: begin
            next = (dec_op == OP_ILL) ? HALT : RS1;
         end
         RS1: begin
            rf_addr_sel = rs1_q;
            rf_ren      = 1'b1;
            rf_bus_en   = 1'b1;
            a_en        = 1'b1;
            next        = (op_q == OP_ADDI) ? IMM : RS2;
         end
         RS2: begin
            rf_addr_sel = rs2_q;
            rf_ren      = 1'b1;
            rf_bus_en   = 1'b1;
            b_en        = 1'b1;
            next        = EXEC;
         end
         IMM: begin
            immgen_bus_en = 1'b1;
            b_en          = 1'b1;
            next          = EXEC;
         end
         EXEC: begin
            ALU_bus_en   = 1'b1;
            rf_addr_sel  = rd_q;
            sel_alu_func = (op_q == OP_SUB);
            rf_wen       = (rd_q != 5'd0);
            next         = UPDATE_PC;
         end
         UPDATE_PC: begin
            pc_inc = 1'b1;
            next   = FETCH_REQ;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: next = FETCH_REQ;
      endcase
      if (rst) begin
         mem_req       = 1'b0;
         ir_en         = 1'b0;
         a_en          = 1'b0;
         b_en          = 1'b0;
         pc_en         = 1'b0;
         immgen_bus_en = 1'b0;
         ALU_bus_en    = 1'b0;
         pc_bus_en     = 1'b0;
         rf_bus_en     = 1'b0;
         rd_bus_en     = 1'b0;
         rf_wen        = 1'b0;
         rf_ren        = 1'b0;
         rf_addr_sel   = '0;
         sel_alu_func  = 1'b0;
         pc_inc        = 1'b0;
         halted        = 1'b0;
      end
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  in  1  single clock, all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 instr  in  32  instruction register contents from datapath; valid from the cycle after ir_en pulse.
REQ-004 ALU_carry  in  1  datapath ALU carry-out.
REQ-005 mem_ack  in  1  memory read acknowledge; rd_data valid on datapath in the cycle mem_ack=1.
REQ-006 mem_req  out  1  instruction read request; address = databus (PC).
REQ-007 ir_en, a_en, b_en, pc_en  out  1 each  datapath register load enables.
REQ-008 immgen_bus_en, ALU_bus_en, pc_bus_en, rf_bus_en, rd_bus_en  out  1 each  datapath bus driver enables.
REQ-009 rf_wen, rf_ren  out  1 each  register-file write/read enables.
REQ-010 rf_addr_sel  out  5  register-file address.
REQ-011 sel_alu_func  out  1  0=add, 1=sub.
REQ-012 pc_inc  out  1  one-cycle pulse; datapath adds 4 to PC.
REQ-013 carry_flag  out  1  ALU_carry captured in last EXEC.
REQ-014 halted  out  1  high in HALT.
REQ-015 instret  out  32  retired-instruction count.

Function
REQ-016 Moore FSM, states: FETCH_REQ, FETCH_LD, DECODE, RS1, RS2, IMM, EXEC, UPDATE_PC, HALT; all control outputs decoded from the current state plus the latched fields.
REQ-017 FETCH_REQ: pc_bus_en=1, mem_req=1; stay until mem_ack=1 sampled, then go to FETCH_LD.
REQ-018 FETCH_LD: rd_bus_en=1, ir_en=1; go to DECODE.
REQ-019 DECODE: latch rd=instr[11:7], rs1=instr[19:15], rs2=instr[24:20], and the op class; no datapath enables asserted.
REQ-020 Op classes: opcode 0110011, funct3 000, funct7 0000000 = ADD; same with funct7 0100000 = SUB; opcode 0010011, funct3 000 = ADDI; all other encodings are illegal.
REQ-021 DECODE transitions: legal class goes to RS1; illegal goes to HALT.
REQ-022 RS1: rf_addr_sel=rs1, rf_ren=1, rf_bus_en=1, a_en=1; next state is RS2 for ADD/SUB, IMM for ADDI.
REQ-023 RS2: rf_addr_sel=rs2, rf_ren=1, rf_bus_en=1, b_en=1; go to EXEC.
REQ-024 IMM: immgen_bus_en=1, b_en=1; go to EXEC.
REQ-025 EXEC: ALU_bus_en=1, rf_addr_sel=rd, sel_alu_func=1 only for SUB; rf_wen=1 unless rd=0; carry_flag<=ALU_carry; go to UPDATE_PC.
REQ-026 UPDATE_PC: pc_inc=1, instret<=instret+1 (wraps 0xFFFFFFFF->0); go to FETCH_REQ.
REQ-027 Cycle counts: ADD/SUB/ADDI take 6 cycles plus FETCH_REQ wait cycles, i.e. 7 cycles with immediate ack.
REQ-028 HALT: all enables 0, halted=1; exit only via rst.
REQ-029 Bus exclusivity: at most one *_bus_en high in any cycle; ir_en and a_en never high together.
REQ-030 rf_addr_sel=0 and sel_alu_func=0 in every state not listed above as driving them.
REQ-031 mem_ack outside FETCH_REQ is ignored.

Reset
REQ-032 rst=1 at an edge: state<=FETCH_REQ, carry_flag<=0, halted<=0, instret<=0, latched fields<=0.
REQ-033 While rst=1, every control output (including mem_req) is forced to 0 combinationally; mem_req rises in the first cycle with rst=0.
REQ-034 rst mid-instruction aborts it: no rf_wen, no pc_inc, no instret change after the reset edge.

Verification
REQ-035 Release reset, instr=0x002081B3 (add x3,x1,x2), mem_ack=1 immediately -> mem_req cycle 0; ir_en cycle 1; RS1 with sel=1 and a_en; RS2 with sel=2 and b_en; EXEC with rf_wen and sel=3; pc_inc cycle 6; instret=1.
REQ-036 instr=0x402081B3 (sub), ALU_carry=1 in EXEC -> sel_alu_func=1 in EXEC only; carry_flag=1 from the next cycle.
REQ-037 instr=0x00500093 (addi x1,x0,5) -> IMM state asserts immgen_bus_en and b_en; no RS2 state; rf_wen with rf_addr_sel=1.
REQ-038 instr=0x00000033 (add x0) -> EXEC with rf_wen=0; pc_inc still pulses; instret increments.
REQ-039 mem_ack held 0 for 3 cycles -> mem_req and pc_bus_en held for 4 cycles; then instr=0xFFFFFFFF -> HALT, halted=1, no outputs thereafter until rst.
REQ-040 rst asserted during RS2 -> all outputs 0 the following cycle; instret and rf_wen unchanged; throughout, assert one-hot bus enables every cycle.
